// File: rtl/video_timing_generator.sv
// Parametrised raster timing generator: pixel/line counters with registered sync,
// active-video and single-cycle line/frame/vertical-interrupt strobes.
module video_timing_generator #(
  parameter int H_VISIBLE = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_VISIBLE = 240,
  parameter int V_FRONT   = 14,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 5,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int VINT_LINE = 240,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start,
  output logic             vint
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (H_TOTAL - 1 > CNT_MAX) begin : g_bad_htotal
    $error("video_timing_generator: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if (V_TOTAL - 1 > CNT_MAX) begin : g_bad_vtotal
    $error("video_timing_generator: V_TOTAL-1 does not fit in CNT_W bits");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("video_timing_generator: sync widths must be non-zero");
  end
  if (VINT_LINE >= V_TOTAL) begin : g_bad_vint
    $error("video_timing_generator: VINT_LINE must be below V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] VINT_POS  = CNT_W'(VINT_LINE);
  localparam logic             HS_ON     = (HSYNC_POL != 0);
  localparam logic             VS_ON     = (VSYNC_POL != 0);

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, enter_line, hs_act, vs_act, de_nxt;

  // Decode from next-state counters so registered outputs line up with hpos/vpos.
  always_comb begin
    h_wrap = (hpos == H_LAST);
    h_nxt  = hpos;
    v_nxt  = vpos;
    if (ce) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = (vpos == V_LAST) ? '0 : vpos + 1'b1;
      end else begin
        h_nxt = hpos + 1'b1;
      end
    end
    enter_line = ce && h_wrap;
    hs_act     = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_act     = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    de_nxt     = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vint        <= 1'b0;
    end else begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= hs_act ? HS_ON : ~HS_ON;
      vsync       <= vs_act ? VS_ON : ~VS_ON;
      display_on  <= de_nxt;
      line_start  <= enter_line;
      frame_start <= enter_line && (v_nxt == '0);
      vint        <= enter_line && (v_nxt == VINT_POS);
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench: a default-mode instance at full rate plus a small inverted-polarity instance
// under random / 1-in-4 enables, both checked against a linear-pixel-index model.
module tb_video_timing_generator;

  localparam int NCYC = 81400;
  localparam int HT0 = 309, VT0 = 262;
  localparam int HT1 = 15,  VT1 = 10;

  logic clk = 1'b0;
  logic rst0, rst1, ce0, ce1;
  logic hs0, vs0, de0, ls0, fs0, vi0;
  logic hs1, vs1, de1, ls1, fs1, vi1;
  logic [8:0] hp0, vp0;
  logic [4:0] hp1, vp1;
  logic [23:0] pack0, pack1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  video_timing_generator dut0 (
    .clk(clk), .reset(rst0), .ce(ce0), .hsync(hs0), .vsync(vs0), .display_on(de0),
    .hpos(hp0), .vpos(vp0), .line_start(ls0), .frame_start(fs0), .vint(vi0)
  );

  video_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .VINT_LINE(0), .CNT_W(5)
  ) dut1 (
    .clk(clk), .reset(rst1), .ce(ce1), .hsync(hs1), .vsync(vs1), .display_on(de1),
    .hpos(hp1), .vpos(vp1), .line_start(ls1), .frame_start(fs1), .vint(vi1)
  );

  assign pack0 = {hp0, vp0, hs0, vs0, de0, ls0, fs0, vi0};
  assign pack1 = {4'b0, hp1, 4'b0, vp1, hs1, vs1, de1, ls1, fs1, vi1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pix = number of pixel advances since reset, taken modulo the frame size.
  function automatic logic [23:0] mdl(input int pix, input bit adv,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb,
      input int hpol, input int vpol, input int vil);
    int ht, h, v;
    bit hs_a, vs_a, de, ls;
    ht   = hv + hf + hs + hb;
    h    = pix % ht;
    v    = pix / ht;
    hs_a = (h >= hv + hf) && (h < hv + hf + hs);
    vs_a = (v >= vv + vf) && (v < vv + vf + vs);
    de   = (h < hv) && (v < vv);
    ls   = adv && (h == 0);
    return {9'(h), 9'(v), hs_a ? hpol[0] : !hpol[0], vs_a ? vpol[0] : !vpol[0], de,
            ls, ls && (v == 0), ls && (v == vil)};
  endfunction

  function automatic logic [23:0] mdl0(input int pix, input bit adv);
    return mdl(pix, adv, 256, 7, 23, 23, 240, 14, 3, 5, 0, 0, 240);
  endfunction

  function automatic logic [23:0] mdl1(input int pix, input bit adv);
    return mdl(pix, adv, 8, 2, 3, 2, 6, 1, 2, 1, 1, 1, 0);
  endfunction

  initial begin
    int pix0, pix1, hs_lo, vs_lo, last_ls1;
    bit adv0, adv1, seen_fs, seen_ls, seen_vi;
    pix0 = 0; pix1 = 0; hs_lo = 0; vs_lo = 0; last_ls1 = -1;
    seen_fs = 0; seen_ls = 0; seen_vi = 0;
    rst0 = 1'b0; rst1 = 1'b0; ce0 = 1'b1; ce1 = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("reset0", pack0, mdl0(0, 0));
      chk("reset1", pack1, mdl1(0, 0));
    end
    rst0 = 1'b1;
    rst1 = 1'b1;

    for (int n = 1; n <= NCYC; n++) begin
      @(negedge clk);
      adv0 = rst0 && ce0;
      if (!rst0) pix0 = 0; else if (ce0) pix0 = (pix0 + 1) % (HT0 * VT0);
      adv1 = rst1 && ce1;
      if (!rst1) pix1 = 0; else if (ce1) pix1 = (pix1 + 1) % (HT1 * VT1);

      if (errors < 40) begin
        chk("dut0", pack0, mdl0(pix0, adv0));
        chk("dut1", pack1, mdl1(pix1, adv1));
      end

      // Full-rate timing landmarks of the default mode.
      if (n <= HT0 && !hs0) hs_lo++;
      if (n <= HT0 * VT0 && !vs0) vs_lo++;
      if (n == HT0) chk("hsync_width", hs_lo, 23);
      if (n == HT0 * VT0) chk("vsync_width", vs_lo, 3 * HT0);
      if (ls0 && !seen_ls) begin seen_ls = 1; chk("line_period", n, HT0); end
      if (vi0 && !seen_vi) begin seen_vi = 1; chk("vint_time", n, 240 * HT0); end
      if (fs0 && !seen_fs) begin
        seen_fs = 1;
        chk("frame_period", n, HT0 * VT0);
        chk("fs_with_ls", ls0, 1'b1);
      end

      // 1-in-4 enable window on the small mode: line takes 4*H_TOTAL clocks.
      if (n >= 20000 && n < 21000 && ls1) begin
        if (last_ls1 >= 0) chk("line_period_ce4", n - last_ls1, 4 * HT1);
        last_ls1 = n;
      end

      // Mid-frame asynchronous reset of the small instance.
      if (n == 21500) begin
        rst1 = 1'b0;
        #1;
        chk("async_reset", pack1, mdl1(0, 0));
      end
      if (n == 21503) rst1 = 1'b1;

      ce0 = (n < 81000) ? 1'b1 : 1'($urandom_range(0, 1));
      if (n >= 19999 && n < 20999) ce1 = ((n + 1) % 4 == 0);
      else ce1 = ($urandom_range(0, 2) != 0);
    end

    if (!seen_fs) chk("frame_start_seen", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
